// File: rtl/reg_snap_pkg.sv
// Shared types and helpers for the register snapshot reader.
//   snap_state_t : reader FSM states (IDLE, SEND)
//   idx_w()      : index width needed to address n words (at least 1 bit)
package reg_snap_pkg;

  typedef enum logic {IDLE, SEND} snap_state_t;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low clear
//   inc   : increment enable; ignored once count is all-ones
//   count : current count value
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/reg_snapshot_reader.sv
// Register snapshot reader: on cap_i, samples the whole register bank into a shadow copy on a
// single edge, then streams the shadow words one per valid/ready handshake.
// Ports:
//   clk, rst_n    : clock (rising edge) and asynchronous active-low reset
//   cap_i         : capture strobe
//   reg_i         : packed register bank, word k at reg_i[k*DATA_W +: DATA_W]
//   out_valid_o   : a shadow word is presented
//   out_ready_i   : consumer accepts the presented word
//   out_data_o    : shadow word at out_idx_o
//   out_idx_o     : index of the presented word
//   out_last_o    : presented word is the final one of the snapshot
//   busy_o        : streaming a snapshot
//   drop_cnt_o    : saturating count of captures ignored while busy
module reg_snapshot_reader
  import reg_snap_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 3,
  parameter int unsigned CNT_W    = 8,
  localparam int unsigned IDX_W   = idx_w(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cap_i,
  input  logic [NUM_REGS*DATA_W-1:0] reg_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_W-1:0]          out_data_o,
  output logic [IDX_W-1:0]           out_idx_o,
  output logic                       out_last_o,
  output logic                       busy_o,
  output logic [CNT_W-1:0]           drop_cnt_o
);

  snap_state_t       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic              load;
  logic              drop;
  logic              xfer;
  logic              at_last;

  always_comb begin
    at_last = (idx_q == IDX_W'(NUM_REGS - 1));
    xfer    = (state_q == SEND) && out_ready_i;
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cap_i) begin
          load    = 1'b1;
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (xfer && at_last) begin
          // Final word leaves this edge: a coincident capture starts the next snapshot
          // with no bubble instead of being dropped.
          idx_d = '0;
          if (cap_i) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) begin
            idx_d = idx_q + IDX_W'(1);
          end
          drop = cap_i;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Every word loads on the same edge so a snapshot is never a mix of two bank states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow_q[k] <= '0;
      end
    end else if (load) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow_q[k] <= reg_i[k*DATA_W +: DATA_W];
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop),
    .count (drop_cnt_o)
  );

  assign out_valid_o = (state_q == SEND);
  assign busy_o      = (state_q == SEND);
  assign out_data_o  = shadow_q[idx_q];
  assign out_idx_o   = idx_q;
  assign out_last_o  = at_last;

endmodule
